comparador_constante_seq: RTL and testbench
===========================================

Name: comparador_constante_seq

Overview:
- Parametrised, registered successor to the team's 4-bit constant-equality comparator.
- Compares a stream of WIDTH-bit samples against a programmable, maskable reference word.
- Selectable relation: EQ, NE, LT or GT.
- Counts matches and flags a run of consecutive matching samples.
- Sits between sampled input buses and the control/monitor logic that needs a debounced "value seen" indication.

Parameters:
- WIDTH, 4: width of sample, reference and mask.
- CNT_W, 8: width of the saturating total-match counter.
- RUN_W, 4: width of the consecutive-match run counter and the run_len threshold.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x carries a sample this cycle.
- x  input  WIDTH  sample; bit WIDTH-1 is the MSB (the old module's a).
- ref_we  input  1  load ref_val/ref_mask into the reference registers.
- ref_val  input  WIDTH  new reference constant.
- ref_mask  input  WIDTH  new compare mask; 1 = bit participates.
- mode  input  2  relation select: 00 EQ, 01 NE, 10 LT, 11 GT.
- run_len  input  RUN_W  consecutive-match threshold for detect.
- clr  input  1  synchronous clear of the counters and detect.
- out_valid  output  1  result outputs are valid this cycle.
- eq  output  1  masked x == ref.
- lt  output  1  masked x < ref, unsigned.
- gt  output  1  masked x > ref, unsigned.
- q  output  1  result of the relation selected by mode.
- detect  output  1  run of matches has reached the threshold.
- match_cnt  output  CNT_W  saturating count of samples with q=1.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - ref_val register = 0; ref_mask register = all ones.
  - out_valid, eq, lt, gt, q, detect = 0.
  - match_cnt = 0; internal run counter = 0.
- Reference load: when ref_we=1, the registers load on that edge.
  - A sample presented in the same cycle as ref_we uses the OLD reference.
  - The new reference applies from the next cycle.
- Compare (combinational on the input side, registered on the output side):
  - xm = x & mask; rm = ref & mask.
  - eq = (xm == rm); lt = (xm < rm) unsigned; gt = (xm > rm) unsigned.
  - Exactly one of eq/lt/gt is 1 whenever out_valid=1.
  - mask = 0 forces eq=1, lt=0, gt=0.
  - q = eq, !eq, lt or gt according to mode.
  - mode is sampled in the same cycle as the sample.
- Latency: exactly 1 cycle.
  - out_valid = in_valid delayed one cycle.
  - eq/lt/gt/q update only on cycles with in_valid=1 and hold their last value otherwise.
  - Consumers qualify them with out_valid.
  - No backpressure: one sample per cycle is accepted, back-to-back.
- Run counter (internal, RUN_W bits), on each valid sample:
  - If q_next=1, increment, saturating at 2^RUN_W-1.
  - If q_next=0, clear to 0.
  - Gaps with in_valid=0 do not break the run.
- detect, registered and updated together with q:
  - detect = 1 when the updated run count >= max(run_len, 1); run_len = 0 behaves as 1.
  - detect drops on the first valid non-matching sample.
  - A change of run_len takes effect on the next valid sample only.
- match_cnt: increments by 1 per valid sample with q_next=1 and saturates at 2^CNT_W-1 (no wrap).
- clr:
  - Clears match_cnt, the run counter and detect on the next edge.
  - clr has priority over a same-cycle sample: counters end at 0, not 1.
  - That sample's eq/lt/gt/q/out_valid are still produced normally.
- Reset mid-operation: all state returns to its reset values immediately; an in-flight sample is dropped (out_valid = 0 after release).
- Simultaneous ref_we and clr: both take effect; they are independent.

Test Plan:
- Reset, then ref_we with ref=0101, mask=1111, mode=EQ, run_len=1; x=0101 valid at cycle t -> at t+1 out_valid=1, eq=1, q=1, detect=1, match_cnt=1; x=0110 -> gt=1, q=0, detect=0, match_cnt=1.
- Mask test: ref=0101, mask=1100; x=0111 and x=0100 -> eq=1 both; x=1000 -> gt=1, lt=0; mask=0000, any x -> eq=1.
- Modes with ref=0101: x=0011 with LT -> q=1; same x with GT -> q=0; x=0101 with NE -> q=0.
- Run threshold run_len=3, EQ: samples hit,hit,(idle),hit -> detect rises on the third valid hit only; next miss -> detect=0 and the run restarts.
- Saturation with CNT_W=8: 300 consecutive matches -> match_cnt=255 and stays; clr together with a matching sample -> match_cnt=0, detect=0, q=1.
- ref_we in the same cycle as x=1010, old ref=0101, new ref=1010 -> eq=0 for that sample; the next x=1010 -> eq=1. Assert rst_n mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/comparador_constante_seq.sv
// ============================================================================
// Module   : comparador_constante_seq
// Brief    : Registered, maskable comparator of a sample stream against a
//            programmable reference, with match counter and run detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparador_constante_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic             ref_we_i,
    input  logic [WIDTH-1:0] ref_val_i,
    input  logic [WIDTH-1:0] ref_mask_i,
    input  logic [1:0]       mode_i,
    input  logic [RUN_W-1:0] run_len_i,
    input  logic             clr_i,
    output logic             out_valid_o,
    output logic             eq_o,
    output logic             lt_o,
    output logic             gt_o,
    output logic             q_o,
    output logic             detect_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam logic [1:0] MODE_EQ = 2'b00;
    localparam logic [1:0] MODE_NE = 2'b01;
    localparam logic [1:0] MODE_LT = 2'b10;
    localparam logic [1:0] MODE_GT = 2'b11;

    logic [WIDTH-1:0] ref_val_q,  ref_val_d;
    logic [WIDTH-1:0] ref_mask_q, ref_mask_d;
    logic             out_valid_q, out_valid_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             res_q, res_d;
    logic             detect_q, detect_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [RUN_W-1:0] run_q, run_d;

    logic [WIDTH-1:0] xm, rm;
    logic             cmp_eq, cmp_lt, cmp_gt, q_next;
    logic [RUN_W-1:0] run_thr;

    // The comparison always uses the reference currently held, so a sample
    // arriving alongside ref_we sees the old value.
    always_comb begin
        xm     = x_i & ref_mask_q;
        rm     = ref_val_q & ref_mask_q;
        cmp_eq = (xm == rm);
        cmp_lt = (xm < rm);
        cmp_gt = (xm > rm);
    end

    always_comb begin
        q_next = cmp_eq;
        case (mode_i)
            MODE_EQ: q_next = cmp_eq;
            MODE_NE: q_next = ~cmp_eq;
            MODE_LT: q_next = cmp_lt;
            MODE_GT: q_next = cmp_gt;
            default: q_next = cmp_eq;
        endcase
    end

    assign run_thr = (run_len_i == '0) ? RUN_W'(1) : run_len_i;

    always_comb begin
        ref_val_d   = ref_val_q;
        ref_mask_d  = ref_mask_q;
        out_valid_d = in_valid_i;
        eq_d        = eq_q;
        lt_d        = lt_q;
        gt_d        = gt_q;
        res_d       = res_q;
        run_d       = run_q;
        detect_d    = detect_q;
        match_cnt_d = match_cnt_q;

        if (ref_we_i) begin
            ref_val_d  = ref_val_i;
            ref_mask_d = ref_mask_i;
        end

        if (in_valid_i) begin
            eq_d  = cmp_eq;
            lt_d  = cmp_lt;
            gt_d  = cmp_gt;
            res_d = q_next;
        end

        // clr wins over a same-cycle sample for all counting state.
        if (clr_i) begin
            run_d       = '0;
            detect_d    = 1'b0;
            match_cnt_d = '0;
        end else if (in_valid_i) begin
            if (q_next) begin
                if (run_q != '1) begin
                    run_d = run_q + RUN_W'(1);
                end
                if (match_cnt_q != '1) begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                end
            end else begin
                run_d = '0;
            end
            detect_d = (run_d >= run_thr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_val_q   <= '0;
            ref_mask_q  <= '1;
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            res_q       <= 1'b0;
            run_q       <= '0;
            detect_q    <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            ref_val_q   <= ref_val_d;
            ref_mask_q  <= ref_mask_d;
            out_valid_q <= out_valid_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            gt_q        <= gt_d;
            res_q       <= res_d;
            run_q       <= run_d;
            detect_q    <= detect_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign eq_o        = eq_q;
    assign lt_o        = lt_q;
    assign gt_o        = gt_q;
    assign q_o         = res_q;
    assign detect_o    = detect_q;
    assign match_cnt_o = match_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_comparador_constante_seq.sv
// ============================================================================
// Module   : tb_comparador_constante_seq
// Brief    : Scoreboard bench for comparador_constante_seq (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparador_constante_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid_i;
    logic [3:0] x_i;
    logic       ref_we_i;
    logic [3:0] ref_val_i;
    logic [3:0] ref_mask_i;
    logic [1:0] mode_i;
    logic [3:0] run_len_i;
    logic       clr_i;
    logic       out_valid_o, eq_o, lt_o, gt_o, q_o, detect_o;
    logic [7:0] match_cnt_o;

    comparador_constante_seq #(.WIDTH(4), .CNT_W(8), .RUN_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .x_i        (x_i),
        .ref_we_i   (ref_we_i),
        .ref_val_i  (ref_val_i),
        .ref_mask_i (ref_mask_i),
        .mode_i     (mode_i),
        .run_len_i  (run_len_i),
        .clr_i      (clr_i),
        .out_valid_o(out_valid_o),
        .eq_o       (eq_o),
        .lt_o       (lt_o),
        .gt_o       (gt_o),
        .q_o        (q_o),
        .detect_o   (detect_o),
        .match_cnt_o(match_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ov;
        logic       eq;
        logic       lt;
        logic       gt;
        logic       q;
        logic       det;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [3:0] m_ref, m_mask;
    int         m_run, m_cnt;
    logic       m_det, m_eq, m_lt, m_gt, m_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_ref  = 4'h0;
        m_mask = 4'hF;
        m_run  = 0;
        m_cnt  = 0;
        m_det  = 1'b0;
        m_eq   = 1'b0;
        m_lt   = 1'b0;
        m_gt   = 1'b0;
        m_q    = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic cycle(input logic v, input logic [3:0] xv, input logic [1:0] md,
                         input logic [3:0] rl, input logic c, input logic we,
                         input logic [3:0] rv, input logic [3:0] rmk);
        logic [3:0] xm, rm;
        int         thr;
        exp_t       e, o;
        in_valid_i = v;  x_i = xv; mode_i = md; run_len_i = rl;
        clr_i = c; ref_we_i = we; ref_val_i = rv; ref_mask_i = rmk;

        if (v) begin
            xm   = xv & m_mask;
            rm   = m_ref & m_mask;
            m_eq = (xm == rm);
            m_lt = (xm < rm);
            m_gt = (xm > rm);
            case (md)
                2'b00:   m_q = m_eq;
                2'b01:   m_q = !m_eq;
                2'b10:   m_q = m_lt;
                default: m_q = m_gt;
            endcase
        end
        if (c) begin
            m_run = 0; m_cnt = 0; m_det = 1'b0;
        end else if (v) begin
            if (m_q) begin
                if (m_run < 15)  m_run++;
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_run = 0;
            end
            thr   = (rl == 0) ? 1 : int'(rl);
            m_det = (m_run >= thr);
        end
        if (we) begin
            m_ref = rv; m_mask = rmk;
        end
        e = '{ov: v, eq: m_eq, lt: m_lt, gt: m_gt, q: m_q, det: m_det, cnt: 8'(m_cnt)};
        sb.push_back(e);

        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("out_valid", 32'(out_valid_o), 32'(o.ov));
        check("eq",        32'(eq_o),        32'(o.eq));
        check("lt",        32'(lt_o),        32'(o.lt));
        check("gt",        32'(gt_o),        32'(o.gt));
        check("q",         32'(q_o),         32'(o.q));
        check("detect",    32'(detect_o),    32'(o.det));
        check("match_cnt", 32'(match_cnt_o), 32'(o.cnt));
    endtask

    task automatic sample(input logic [3:0] xv, input logic [1:0] md, input logic [3:0] rl);
        cycle(1'b1, xv, md, rl, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic load_ref(input logic [3:0] rv, input logic [3:0] rmk);
        cycle(1'b0, 4'h0, 2'b00, 4'd1, 1'b0, 1'b1, rv, rmk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ov"},  32'(out_valid_o), 32'd0);
        check({tag, "_eq"},  32'(eq_o),        32'd0);
        check({tag, "_lt"},  32'(lt_o),        32'd0);
        check({tag, "_gt"},  32'(gt_o),        32'd0);
        check({tag, "_q"},   32'(q_o),         32'd0);
        check({tag, "_det"}, 32'(detect_o),    32'd0);
        check({tag, "_cnt"}, 32'(match_cnt_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid_i = 1'b0; x_i = '0; ref_we_i = 1'b0;
        ref_val_i = '0; ref_mask_i = '0; mode_i = 2'b00; run_len_i = 4'd1; clr_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic equality
        load_ref(4'b0101, 4'b1111);
        sample(4'b0101, 2'b00, 4'd1);
        check("basic_eq",  32'(eq_o),        32'd1);
        check("basic_det", 32'(detect_o),    32'd1);
        check("basic_cnt", 32'(match_cnt_o), 32'd1);
        sample(4'b0110, 2'b00, 4'd1);
        check("basic_gt",  32'(gt_o),        32'd1);
        check("basic_q0",  32'(q_o),         32'd0);
        check("basic_cnt1",32'(match_cnt_o), 32'd1);

        // Mask
        load_ref(4'b0101, 4'b1100);
        sample(4'b0111, 2'b00, 4'd1);
        check("mask_eq_a", 32'(eq_o), 32'd1);
        sample(4'b0100, 2'b00, 4'd1);
        check("mask_eq_b", 32'(eq_o), 32'd1);
        sample(4'b1000, 2'b00, 4'd1);
        check("mask_gt",   32'(gt_o), 32'd1);
        load_ref(4'b0101, 4'b0000);
        sample(4'b1011, 2'b00, 4'd1);
        check("mask0_eq",  32'(eq_o), 32'd1);

        // Modes
        load_ref(4'b0101, 4'b1111);
        sample(4'b0011, 2'b10, 4'd1);
        check("mode_lt", 32'(q_o), 32'd1);
        sample(4'b0011, 2'b11, 4'd1);
        check("mode_gt", 32'(q_o), 32'd0);
        sample(4'b0101, 2'b01, 4'd1);
        check("mode_ne", 32'(q_o), 32'd0);

        // Run threshold with idle gap
        cycle(1'b0, 4'h0, 2'b00, 4'd3, 1'b1, 1'b0, 4'h0, 4'h0);
        sample(4'b0101, 2'b00, 4'd3);
        sample(4'b0101, 2'b00, 4'd3);
        check("run_det2", 32'(detect_o), 32'd0);
        cycle(1'b0, 4'h0, 2'b00, 4'd3, 1'b0, 1'b0, 4'h0, 4'h0);
        sample(4'b0101, 2'b00, 4'd3);
        check("run_det3", 32'(detect_o), 32'd1);
        sample(4'b0000, 2'b00, 4'd3);
        check("run_miss", 32'(detect_o), 32'd0);
        sample(4'b0101, 2'b00, 4'd3);
        check("run_restart", 32'(detect_o), 32'd0);

        // Counter saturation, then clr with a matching sample
        for (int i = 0; i < 300; i++) sample(4'b0101, 2'b00, 4'd1);
        check("sat_cnt", 32'(match_cnt_o), 32'd255);
        cycle(1'b1, 4'b0101, 2'b00, 4'd1, 1'b1, 1'b0, 4'h0, 4'h0);
        check("clr_cnt", 32'(match_cnt_o), 32'd0);
        check("clr_det", 32'(detect_o),    32'd0);
        check("clr_q",   32'(q_o),         32'd1);

        // ref_we in the same cycle as a sample
        cycle(1'b1, 4'b1010, 2'b00, 4'd1, 1'b0, 1'b1, 4'b1010, 4'b1111);
        check("refwe_old", 32'(eq_o), 32'd0);
        sample(4'b1010, 2'b00, 4'd1);
        check("refwe_new", 32'(eq_o), 32'd1);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom),
                  4'($urandom_range(0, 4)), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom));
        end

        // Asynchronous reset mid-stream
        sample(4'b1010, 2'b00, 4'd1);
        in_valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 4'h0, 2'b00, 4'd1, 1'b0, 1'b0, 4'h0, 4'h0);
        sample(4'b0000, 2'b00, 4'd1);
        check("post_rst_eq", 32'(eq_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
